rtf65002_muldiv_seq: RTL and testbench
======================================

RTF65002_MULDIV_SEQ -- requirements
Module: rtf65002_muldiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  operation request; sampled only in IDLE or DONE.
REQ-005 abort  input  1  cancel an in-flight operation.
REQ-006 op  input  2  operation: 00 MULU, 01 MULS (signed), 10 DIVU (quotient), 11 MODU (remainder).
REQ-007 a  input  32  multiplicand or dividend, captured on accepted start.
REQ-008 b  input  32  multiplier or divisor, captured on accepted start.
REQ-009 busy  output  1  high while an operation is in progress (MUL, DIV or FIX state).
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 prod  output  64  product; feeds the ALU TSR 2/3 path.
REQ-012 quo  output  32  quotient.
REQ-013 rem  output  32  remainder.
REQ-014 dbz  output  1  divide-by-zero flag of the last completed operation.

Function
REQ-015 The block SHALL use the states IDLE, MUL, DIV, FIX and DONE.
REQ-016 A start SHALL be accepted at an edge where the state is IDLE or DONE, start=1 and abort=0; operands and op SHALL be latched at that edge (call it T).
REQ-017 An accepted MULU or MULS SHALL enter MUL for exactly 32 cycles (T+1..T+32), one shift-add iteration per cycle on a 64-bit accumulator.
REQ-018 For MULS, the sequencer SHALL multiply |a| by |b| and negate the 64-bit result in FIX when a[31]^b[31]=1.
REQ-019 An accepted DIVU or MODU with b!=0 SHALL enter DIV for exactly 32 cycles, one restoring-division step per cycle, unsigned.
REQ-020 After MUL or DIV the state SHALL be FIX for one cycle (T+33), then DONE (T+34); done=1 only in DONE, so start-to-done latency is 34 cycles for every op except divide-by-zero.
REQ-021 On entering DONE, the sequencer SHALL update prod (MUL ops) or both quo and rem (DIV ops); the non-updated outputs keep their prior values. All outputs SHALL hold until the next completion.
REQ-022 DIVU/MODU with b==0 SHALL go directly to DONE at T+1 with dbz=1, quo=32'hFFFFFFFF and rem=a; no iterations run.
REQ-023 dbz SHALL be updated at every completion: 1 for divide-by-zero, 0 otherwise.
REQ-024 DONE SHALL last one cycle, then go to IDLE, unless a start is accepted in DONE (back-to-back), in which case the next state follows REQ-017/019/022.
REQ-025 start while busy=1 SHALL be ignored, with no queuing and no effect on the running operation.
REQ-026 abort=1 in MUL, DIV or FIX SHALL return the state to IDLE at the next edge with no done pulse and no output update.
REQ-027 abort=1 with start=1 in IDLE or DONE SHALL prevent acceptance, and the state goes to IDLE.
REQ-028 The iteration counter SHALL be 6 bits, cleared on accept, and SHALL exit at count 31 with no wrap.
REQ-029 busy SHALL be a registered decode of state; it is 0 in IDLE and DONE.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, dbz=0, prod=0, quo=0, rem=0 and counter=0, including mid-operation.
REQ-031 After rst_n deasserts, the first edge SHALL be able to accept a start.

Verification
REQ-032 The bench SHALL cover MULU: a=7, b=6 at T -> busy T+1..T+33; done at T+34 with prod=64'd42.
REQ-033 The bench SHALL cover MULS: a=-3, b=5 -> prod=64'hFFFFFFFF_FFFFFFF1 at T+34; a=b=32'h80000000 -> prod=64'h40000000_00000000.
REQ-034 The bench SHALL cover DIVU then MODU: a=100, b=7 -> quo=14, rem=2, dbz=0 at T+34; the second op starts in the DONE cycle and completes 34 cycles later.
REQ-035 The bench SHALL cover divide-by-zero: DIVU a=55, b=0 -> done at T+1 with dbz=1, quo=FFFFFFFF, rem=55.
REQ-036 The bench SHALL cover abort and stray starts: abort at T+10 -> IDLE at T+11, no done, outputs unchanged; start at T+5 during busy -> ignored, original op completes at T+34.
REQ-037 The bench SHALL cover reset mid-operation: rst_n low at T+20 -> all outputs 0 immediately, no done; a new start after release completes normally.

Source files
------------

// File: rtl/rtf65002_muldiv_seq.sv
// Sequential 32x32 multiplier / 32/32 unsigned divider: one shift-add or
// restoring step per cycle on a shared 64-bit accumulator, 34-cycle latency.
module rtf65002_muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] prod,
  output logic [31:0] quo,
  output logic [31:0] rem,
  output logic        dbz
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_is_div;
  logic        r_neg;

  logic        w_accept, w_dbz, w_busy_nxt, w_done_nxt, w_div_ge;
  logic [32:0] w_mul_sum, w_div_sh, w_div_dif;

  function automatic logic [31:0] f_mag(input logic signed [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] f_neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !abort;
  assign w_dbz    = w_accept && op[1] && (b == 32'd0);

  // High half accumulates the product; for divide it holds the partial remainder
  // while the dividend shifts out of the low half and quotient bits shift in.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_div_sh  = {r_acc[63:32], r_acc[31]};
  assign w_div_dif = w_div_sh - {1'b0, r_opnd};
  assign w_div_ge  = ~w_div_dif[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next = op[1] ? ((b == 32'd0) ? S_DONE : S_DIV) : S_MUL;
        else          w_next = S_IDLE;
      end
      S_MUL, S_DIV: begin
        if (abort)                w_next = S_IDLE;
        else if (r_cnt == 6'd31) w_next = S_FIX;
      end
      S_FIX:   w_next = abort ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_next == S_MUL) || (w_next == S_DIV) || (w_next == S_FIX);
    w_done_nxt = (w_next == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
      prod  <= 64'd0;
      quo   <= 32'd0;
      rem   <= 32'd0;
      r_cnt <= 6'd0;
    end else begin
      busy <= w_busy_nxt;
      done <= w_done_nxt;
      if (w_accept)
        r_cnt <= 6'd0;
      else if ((r_state == S_MUL) || (r_state == S_DIV))
        r_cnt <= r_cnt + 6'd1;
      if ((r_state == S_FIX) && !abort) begin
        dbz <= 1'b0;
        if (r_is_div) begin
          quo <= r_acc[31:0];
          rem <= r_acc[63:32];
        end else begin
          prod <= f_neg64(r_acc, r_neg);
        end
      end else if (w_dbz) begin
        dbz <= 1'b1;
        quo <= 32'hFFFF_FFFF;
        rem <= a;
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_div <= op[1];
      r_neg    <= (op == 2'b01) && (a[31] ^ b[31]);
      r_acc    <= {32'd0, (op == 2'b01) ? f_mag(b) : (op[1] ? a : b)};
      r_opnd   <= (op == 2'b01) ? f_mag(a) : (op[1] ? b : a);
    end else if (r_state == S_MUL) begin
      r_acc <= {w_mul_sum, r_acc[31:1]};
    end else if (r_state == S_DIV) begin
      r_acc <= w_div_ge ? {w_div_dif[31:0], r_acc[30:0], 1'b1}
                        : {w_div_sh[31:0],  r_acc[30:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_rtf65002_muldiv_seq.sv
// Directed bench for rtf65002_muldiv_seq: latency, results, back-to-back,
// divide-by-zero, abort, stray starts and mid-operation reset.
module tb_rtf65002_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  rtf65002_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .prod(prod), .quo(quo),
    .rem(rem), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request through one edge (T); returns #1 after T, where lat=1.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
  endtask

  task automatic step();
    @(posedge clk); #1;
    lat++;
  endtask

  // Wait (bounded) for done; busy must stay high on every cycle before it.
  task automatic wait_done(input string tag, input int exp_lat);
    logic gap = 1'b0;
    while (!done && lat < 60) begin
      if (!busy) gap = 1'b1;
      step();
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_gap"}, gap, 1'b0);
    check({tag, "_busy_in_done"}, busy, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_lat);
    launch(o, x, y);
    wait_done(tag, exp_lat);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_prod", prod, 64'd0);
    check("rst_quo", quo, 32'd0);
    check("rst_rem", rem, 32'd0);
    check("rst_ctl", {busy, done, dbz}, 3'b000);
    rst_n = 1'b1;

    // MULU 7*6, accepted on the first edge after reset release
    launch(2'b00, 32'd7, 32'd6);
    check("mulu_busy_t1", busy, 1'b1);
    while (lat < 33) step();
    check("mulu_t33", {busy, done}, 2'b10);
    wait_done("mulu", 34);
    check("mulu_prod", prod, 64'd42);
    check("mulu_dbz", dbz, 1'b0);
    step();
    check("done_one_cycle", {busy, done}, 2'b00);

    run_op("muls_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 34);
    check("muls_neg_prod", prod, 64'hFFFF_FFFF_FFFF_FFF1);
    check("muls_quo_kept", quo, 32'd0);
    run_op("muls_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 34);
    check("muls_min_prod", prod, 64'h4000_0000_0000_0000);

    // DIVU then MODU started in the DONE cycle
    run_op("divu", 2'b10, 32'd100, 32'd7, 34);
    check("divu_quo", quo, 32'd14);
    check("divu_rem", rem, 32'd2);
    check("divu_dbz", dbz, 1'b0);
    check("divu_prod_kept", prod, 64'h4000_0000_0000_0000);
    run_op("modu_b2b", 2'b11, 32'd100, 32'd7, 34);
    check("modu_quo", quo, 32'd14);
    check("modu_rem", rem, 32'd2);

    step();
    run_op("dbz", 2'b10, 32'd55, 32'd0, 1);
    check("dbz_flag", dbz, 1'b1);
    check("dbz_quo", quo, 32'hFFFF_FFFF);
    check("dbz_rem", rem, 32'd55);
    check("dbz_prod_kept", prod, 64'h4000_0000_0000_0000);
    run_op("after_dbz", 2'b00, 32'd3, 32'd4, 34);
    check("after_dbz_flag", dbz, 1'b0);
    check("after_dbz_prod", prod, 64'd12);

    // Abort seen at edge T+10
    step();
    launch(2'b00, 32'd9, 32'd9);
    while (lat < 10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", {busy, done}, 2'b00);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    check("abort_prod_kept", prod, 64'd12);

    // Stray start while busy must not disturb the running divide
    launch(2'b10, 32'd1000, 32'd10);
    while (lat < 5) step();
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
    step();
    start = 1'b0;
    wait_done("stray", 34);
    check("stray_quo", quo, 32'd100);
    check("stray_rem", rem, 32'd0);
    check("stray_prod_kept", prod, 64'd12);

    // start together with abort in IDLE is refused
    step();
    start = 1'b1; abort = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {busy, done}, 2'b00);
    step();
    check("start_abort_stay", {busy, done}, 2'b00);

    // Reset in the middle of an operation
    launch(2'b00, 32'd5, 32'd5);
    while (lat < 20) step();
    rst_n = 1'b0;
    #1;
    check("rstmid_prod", prod, 64'd0);
    check("rstmid_quo", quo, 32'd0);
    check("rstmid_rem", rem, 32'd0);
    check("rstmid_ctl", {busy, done, dbz}, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_hold", {busy, done}, 2'b00);
    rst_n = 1'b1;
    run_op("after_rst", 2'b00, 32'd5, 32'd5, 34);
    check("after_rst_prod", prod, 64'd25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
